// File: rtl/tone_synth.sv
// tone_synth: turns a 4-bit note code plus a play enable into a 50%-duty
// square wave for the piezo buzzer. A new note is taken only at the end of a
// full period, so the pin never carries a truncated pulse. Rest codes
// (0, 11..15) and a low enable silence the pin, and a silent pin is low.
//
// enable is a level, not a handshake. The sequencer holds it high for the
// whole sound, and dropping it cuts the tone off at the next clock edge.
// tone_active is a direct copy of the FSM state (1 = RUN), so it doubles as
// the state observation point.
module tone_synth #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int COUNT_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] note,
  input  logic       enable,
  output logic       buzzer_out,
  output logic       tone_active
);

  // Half-period in clock cycles, rounded to nearest; f is in centihertz.
  function automatic longint calc_half(input longint f_chz);
    return (longint'(CLK_FREQ) * 50 + f_chz / 2) / f_chz;
  endfunction

  localparam longint H_C6 = calc_half(104650);
  localparam longint H_D6 = calc_half(117466);
  localparam longint H_E6 = calc_half(131851);
  localparam longint H_F6 = calc_half(139691);
  localparam longint H_G6 = calc_half(156798);
  localparam longint H_B6 = calc_half(197553);
  localparam longint H_C7 = calc_half(209300);
  localparam longint H_G5 = calc_half(78399);
  localparam longint H_F4 = calc_half(34923);
  localparam longint H_B3 = calc_half(24694);

  // B3 is the lowest note, so it has the longest half-period.
  localparam longint MAX_HALF  = H_B3;
  localparam longint COUNT_MAX = (longint'(1) << COUNT_BITS) - 1;

  if (MAX_HALF > COUNT_MAX) begin : g_count_too_narrow
    $error("tone_synth: COUNT_BITS too small for the half-period table");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [COUNT_BITS-1:0] counter, counter_nxt;
  logic [3:0]            cur_note, cur_note_nxt;
  logic                  buzzer_nxt;

  function automatic logic note_valid(input logic [3:0] n);
    return (n >= 4'd1) && (n <= 4'd10);
  endfunction

  // Reload value for a half-period: HALF(n)-1. Rest codes never reach this.
  function automatic logic [COUNT_BITS-1:0] half_m1(input logic [3:0] n);
    logic [COUNT_BITS-1:0] h;
    case (n)
      4'd1:    h = COUNT_BITS'(H_C6);
      4'd2:    h = COUNT_BITS'(H_D6);
      4'd3:    h = COUNT_BITS'(H_E6);
      4'd4:    h = COUNT_BITS'(H_F6);
      4'd5:    h = COUNT_BITS'(H_G6);
      4'd6:    h = COUNT_BITS'(H_B6);
      4'd7:    h = COUNT_BITS'(H_C7);
      4'd8:    h = COUNT_BITS'(H_G5);
      4'd9:    h = COUNT_BITS'(H_F4);
      4'd10:   h = COUNT_BITS'(H_B3);
      default: h = COUNT_BITS'(1);
    endcase
    return h - COUNT_BITS'(1);
  endfunction

  // State, counter, note and pin registers; reset silences the pin at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      cur_note   <= '0;
      buzzer_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      cur_note   <= cur_note_nxt;
      buzzer_out <= buzzer_nxt;
    end
  end

  // Next-state logic: start on enable with a valid note, toggle on counter
  // expiry, and accept a note change or a rest only at the low->high boundary.
  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    cur_note_nxt = cur_note;
    buzzer_nxt   = buzzer_out;
    case (state)
      IDLE: begin
        counter_nxt = '0;
        buzzer_nxt  = 1'b0;
        if (enable && note_valid(note)) begin
          state_nxt    = RUN;
          cur_note_nxt = note;
          counter_nxt  = half_m1(note);
          buzzer_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // Immediate cutoff, regardless of where we are in the period.
          state_nxt   = IDLE;
          counter_nxt = '0;
          buzzer_nxt  = 1'b0;
        end else if (counter != '0) begin
          counter_nxt = counter - COUNT_BITS'(1);
        end else if (buzzer_out) begin
          // Mid-period toggle: the note is deliberately not resampled here.
          buzzer_nxt  = 1'b0;
          counter_nxt = half_m1(cur_note);
        end else if (note_valid(note)) begin
          // Full-period boundary: pick up whatever note is requested now.
          cur_note_nxt = note;
          counter_nxt  = half_m1(note);
          buzzer_nxt   = 1'b1;
        end else begin
          // Rest at the boundary: stay low and stop.
          state_nxt   = IDLE;
          counter_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
        buzzer_nxt  = 1'b0;
      end
    endcase
  end

  assign tone_active = (state == RUN);

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth. The main instance runs with a reduced CLK_FREQ so
// that whole periods are short; a second instance at the default clock
// frequency confirms one table entry (C7) against its published value.
module tb_tone_synth;

  localparam int TB_CLK = 250_000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] note = 4'd0;
  logic       en_d = 1'b0;
  logic [3:0] note_d = 4'd7;
  logic       buzzer_out, tone_active;
  logic       buzzer_def, active_def;

  always #5 clk = ~clk;

  tone_synth #(.CLK_FREQ(TB_CLK), .COUNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .note(note), .enable(enable),
    .buzzer_out(buzzer_out), .tone_active(tone_active)
  );

  tone_synth dut_def (
    .clk(clk), .rst_n(rst_n), .note(note_d), .enable(en_d),
    .buzzer_out(buzzer_def), .tone_active(active_def)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The tone is described by its position within the current period:
  // positions 0..H-1 are high, H..2H-1 are low, and at 2H a period is done.
  bit m_active = 1'b0;
  int m_note   = 0;
  int m_pos    = 0;

  function automatic int freq_chz(input int n);
    case (n)
      1: return 104650;  2: return 117466;  3: return 131851;
      4: return 139691;  5: return 156798;  6: return 197553;
      7: return 209300;  8: return 78399;   9: return 34923;
      10: return 24694;
      default: return 0;
    endcase
  endfunction

  function automatic int half_tb(input int n, input int clk_hz);
    longint f;
    f = longint'(freq_chz(n));
    if (f == 0) return 0;
    return int'((longint'(clk_hz) * 50 + f / 2) / f);
  endfunction

  function automatic bit note_ok(input int n);
    return (n >= 1) && (n <= 10);
  endfunction

  task automatic model_step();
    if (!m_active) begin
      if (enable && note_ok(int'(note))) begin
        m_active = 1'b1;
        m_note   = int'(note);
        m_pos    = 0;
      end
    end else if (!enable) begin
      m_active = 1'b0;
    end else begin
      m_pos++;
      if (m_pos == 2 * half_tb(m_note, TB_CLK)) begin
        if (note_ok(int'(note))) begin
          m_note = int'(note);
          m_pos  = 0;
        end else begin
          m_active = 1'b0;
        end
      end
    end
  endtask

  function automatic logic model_buzzer();
    return m_active && (m_pos < half_tb(m_note, TB_CLK));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("buzzer", buzzer_out, model_buzzer());
    check("active", tone_active, m_active);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic e, input int nt);
    enable = e;
    note   = 4'(nt);
  endtask

  // Counts consecutive samples of buzzer_out at lvl, starting with the current one.
  task automatic measure(input logic lvl, output int len);
    len = 0;
    while (buzzer_out == lvl && len < 3000) begin
      len++;
      tick();
    end
  endtask

  task automatic measure_def(input logic lvl, output int len);
    len = 0;
    while (buzzer_def == lvl && len < 70000) begin
      len++;
      tick();
    end
  endtask

  // Asynchronous reset pulse issued between clock edges.
  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_async_buz", buzzer_out, 1'b0);
    check("rst_async_act", tone_active, 1'b0);
    m_active = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_buz", buzzer_out, 1'b0);
    #3;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len;
    int n;

    #2;
    check("reset_buz", buzzer_out, 1'b0);
    check("reset_act", tone_active, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    run(3);

    // C7: rises one cycle after enable, then H high / H low repeating.
    drive(1'b1, 7);
    tick();
    check("c7_rise", buzzer_out, 1'b1);
    measure(1'b1, len); check("c7_high", len, half_tb(7, TB_CLK));
    measure(1'b0, len); check("c7_low", len, half_tb(7, TB_CLK));
    measure(1'b1, len); check("c7_high2", len, half_tb(7, TB_CLK));

    // Change to G6 mid-high: current halves stay C7, then G6 from next rise.
    measure(1'b0, len);
    run(10);
    drive(1'b1, 5);
    measure(1'b1, len);
    measure(1'b0, len); check("chg_old_low", len, half_tb(7, TB_CLK));
    measure(1'b1, len); check("chg_new_high", len, half_tb(5, TB_CLK));
    measure(1'b0, len); check("chg_new_low", len, half_tb(5, TB_CLK));

    // B3 for 3 periods, then drop enable mid-high.
    drive(1'b0, 0);
    run(2);
    drive(1'b1, 10);
    run(6 * half_tb(10, TB_CLK) + 40);
    drive(1'b0, 10);
    tick();
    check("cut_buz", buzzer_out, 1'b0);
    check("cut_act", tone_active, 1'b0);
    run(1200);

    // Rest codes while enabled keep the pin silent; then C6 starts at once.
    drive(1'b1, 0);
    run(2000);
    drive(1'b1, 12);
    run(2000);
    drive(1'b1, 1);
    tick();
    check("c6_rise", buzzer_out, 1'b1);
    measure(1'b1, len); check("c6_high", len, half_tb(1, TB_CLK));

    // Short-lived note change that vanishes before the boundary is ignored.
    measure(1'b0, len);
    run(20);
    drive(1'b1, 4);
    run(15);
    drive(1'b1, 1);
    measure(1'b1, len);
    measure(1'b0, len);
    measure(1'b1, len); check("glitch_ignored", len, half_tb(1, TB_CLK));

    // F4 then rest: tone ends at the next full-period boundary.
    drive(1'b0, 0);
    run(2);
    drive(1'b1, 9);
    run(100);
    drive(1'b1, 0);
    n = 0;
    while (tone_active && n < 1000) begin
      tick();
      n++;
    end
    check("rest_stop_act", tone_active, 1'b0);
    check("rest_stop_buz", buzzer_out, 1'b0);
    run(50);

    // Reset mid-high of E6, enable held: restart high 1 cycle after release.
    drive(1'b0, 0);
    run(2);
    drive(1'b1, 3);
    run(30);
    rst_pulse();
    tick();
    check("rst_restart", buzzer_out, 1'b1);
    measure(1'b1, len); check("rst_e6_high", len, half_tb(3, TB_CLK));

    // Randomized segments of enable/note with occasional reset pulses.
    for (int s = 0; s < 120; s++) begin
      int nt;
      if ($urandom_range(0, 3) != 0) nt = int'($urandom_range(1, 10));
      else nt = int'($urandom_range(0, 15));
      drive(($urandom_range(0, 9) != 0), nt);
      if ($urandom_range(0, 19) == 0) rst_pulse();
      run(int'($urandom_range(1, 600)));
    end

    // Default clock frequency: C7 half-period is 5972 cycles.
    drive(1'b0, 0);
    run(2);
    exp_q.push_back(32'd5972);
    exp_q.push_back(32'd5972);
    en_d = 1'b1;
    tick();
    check("def_rise", buzzer_def, 1'b1);
    check("def_act", active_def, 1'b1);
    measure_def(1'b1, len); check("def_c7_high", len, exp_q.pop_front());
    measure_def(1'b0, len); check("def_c7_low", len, exp_q.pop_front());
    en_d = 1'b0;
    tick();
    check("def_off_buz", buzzer_def, 1'b0);
    check("def_off_act", active_def, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
